// File: rtl/fios_casc_pkg.sv
// fios_casc_pkg: shared types and constants for the cascaded FIOS PE-chain sequencer.
// Holds the per-PE control bundle, its idle value, the OPMODE codes and the
// DSP input-mux selector encodings.
package fios_casc_pkg;

  typedef struct packed {
    logic       a_reg_en;
    logic       m_reg_en;
    logic [1:0] mux_A_sel;
    logic [1:0] mux_B_sel;
    logic [1:0] mux_C_sel;
    logic       CREG_en;
    logic [8:0] OPMODE;
    logic       RES_delay_en;
  } pe_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  // OPMODE codes: product, product plus C, product plus C plus cascaded carry
  localparam logic [8:0] OP_M          = 9'h005;
  localparam logic [8:0] OP_M_C        = 9'h185;
  localparam logic [8:0] OP_M_C_PCIN17 = 9'h1D5;

  // A mux: 0=a, 1=RES, 2=m
  localparam logic [1:0] SEL_A_A    = 2'd0;
  localparam logic [1:0] SEL_A_RES  = 2'd1;
  localparam logic [1:0] SEL_A_M    = 2'd2;
  // B mux: 0=b, 1=p'0, 2=p
  localparam logic [1:0] SEL_B_B    = 2'd0;
  localparam logic [1:0] SEL_B_P0   = 2'd1;
  localparam logic [1:0] SEL_B_P    = 2'd2;
  // C mux: 0=C_i, 1=RES_delay, 2=C delay1, 3=zero
  localparam logic [1:0] SEL_C_CI   = 2'd0;
  localparam logic [1:0] SEL_C_RESD = 2'd1;
  localparam logic [1:0] SEL_C_CD1  = 2'd2;
  localparam logic [1:0] SEL_C_ZERO = 2'd3;

  localparam pe_ctrl_t PE_CTRL_IDLE = '{
    a_reg_en:     1'b0,
    m_reg_en:     1'b0,
    mux_A_sel:    2'd3,
    mux_B_sel:    2'd3,
    mux_C_sel:    2'd3,
    CREG_en:      1'b0,
    OPMODE:       9'h000,
    RES_delay_en: 1'b0
  };

  // Downstream PEs add the carry cascaded from their neighbour in the MP slot.
  // The MP slot is the only one that routes m onto the A port.
  function automatic pe_ctrl_t fn_substMp(input pe_ctrl_t b);
    pe_ctrl_t r;
    r = b;
    if (b.mux_A_sel == SEL_A_M) begin
      r.OPMODE = OP_M_C_PCIN17;
    end
    return r;
  endfunction

endpackage

// File: rtl/fios_casc_ctrl_skew.sv
// ctrl_skew_line: delays the PE0 control bundle by L cycles per PE stage so
// PE k sees the PE0 stream k*L cycles later. Stages feeding PE1 and beyond get
// the cascaded-carry OPMODE in their MP slot. Synchronous active-high clear.
module ctrl_skew_line
  import fios_casc_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int L      = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  pe_ctrl_t                 i_pe0,
  output pe_ctrl_t [NUM_PE-1:0]    o_peCtrl
);

  pe_ctrl_t r_line    [NUM_PE-1][L];
  pe_ctrl_t w_stageIn [NUM_PE-1];

  // First stage takes the PE0 bundle with the MP-slot OPMODE substituted
  always_comb begin
    w_stageIn[0] = fn_substMp(i_pe0);
  end

  for (genvar gs = 1; gs < NUM_PE - 1; gs++) begin : g_chain
    assign w_stageIn[gs] = r_line[gs-1][L-1];
  end

  // Shift every stage by one position each cycle, clearing to the idle bundle on reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_PE - 1; s++) begin
        for (int d = 0; d < L; d++) begin
          r_line[s][d] <= PE_CTRL_IDLE;
        end
      end
    end else begin
      for (int s = 0; s < NUM_PE - 1; s++) begin
        r_line[s][0] <= w_stageIn[s];
        for (int d = 1; d < L; d++) begin
          r_line[s][d] <= r_line[s][d-1];
        end
      end
    end
  end

  assign o_peCtrl[0] = i_pe0;
  for (genvar gk = 1; gk < NUM_PE; gk++) begin : g_out
    assign o_peCtrl[gk] = r_line[gk-1][L-1];
  end

endmodule

// File: rtl/fios_casc_ctrl.sv
// fios_casc_ctrl: sequencer for the cascaded FIOS Montgomery PE chain.
// One modular multiplication per start_i: NUM_PE outer iterations of T=3L
// cycles, then an NUM_PE*L drain that flushes the skew line, then a done pulse.
// Optional busy-cycle counter enabled by defining FIOS_CTRL_CYCLE_CNT_EN.
module fios_casc_ctrl
  import fios_casc_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int ABREG  = 1,
  parameter int MREG   = 1
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(NUM_PE)-1:0]  a_idx_o,
  output pe_ctrl_t [NUM_PE-1:0]      pe_ctrl_o,
  output logic [31:0]                cycles_o
);

  localparam int L     = 1 + ABREG + MREG;
  localparam int T     = 3 * L;
  localparam int DRAIN = NUM_PE * L;
  localparam int CW    = $clog2(T);
  localparam int IW    = $clog2(NUM_PE);
  localparam int DW    = $clog2(DRAIN);

  ctrl_state_t r_state, w_stateNext;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic [IW-1:0] r_iter, w_iterNext;
  logic [DW-1:0] r_drain, w_drainNext;
  pe_ctrl_t      r_pe0, w_pe0Next;

  // State and counter register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_iter  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_iter  <= w_iterNext;
      r_drain <= w_drainNext;
    end
  end

  // Next-state logic: iterate cnt within a period, iter across periods, then drain
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_iterNext  = r_iter;
    w_drainNext = r_drain;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_stateNext = ST_RUN;
          w_cntNext   = '0;
          w_iterNext  = '0;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(T - 1)) begin
          w_cntNext = '0;
          if (r_iter == IW'(NUM_PE - 1)) begin
            w_stateNext = ST_DRAIN;
            w_iterNext  = '0;
            w_drainNext = '0;
          end else begin
            w_iterNext = r_iter + 1'b1;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DW'(DRAIN - 1)) begin
          w_stateNext = ST_DONE;
        end else begin
          w_drainNext = r_drain + 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // PE0 bundle decoded from the upcoming cnt/iter so the registered output lines up with cnt
  always_comb begin
    w_pe0Next = PE_CTRL_IDLE;
    if (w_stateNext == ST_RUN) begin
      if (w_cntNext == CW'(0)) begin
        w_pe0Next.a_reg_en  = 1'b1;
        w_pe0Next.mux_A_sel = SEL_A_A;
        w_pe0Next.mux_B_sel = SEL_B_B;
        w_pe0Next.CREG_en   = 1'b1;
        if (w_iterNext == IW'(0)) begin
          w_pe0Next.OPMODE    = OP_M;
          w_pe0Next.mux_C_sel = SEL_C_ZERO;
        end else begin
          w_pe0Next.OPMODE    = OP_M_C;
          w_pe0Next.mux_C_sel = SEL_C_RESD;
        end
      end
      if (w_cntNext == CW'(L)) begin
        w_pe0Next.mux_A_sel = SEL_A_RES;
        w_pe0Next.mux_B_sel = SEL_B_P0;
        w_pe0Next.OPMODE    = OP_M;
      end
      if (w_cntNext == CW'(2 * L - 1)) begin
        w_pe0Next.m_reg_en = 1'b1;
      end
      if (w_cntNext == CW'(2 * L)) begin
        w_pe0Next.mux_A_sel = SEL_A_M;
        w_pe0Next.mux_B_sel = SEL_B_P;
        w_pe0Next.mux_C_sel = SEL_C_CD1;
        w_pe0Next.CREG_en   = 1'b1;
        w_pe0Next.OPMODE    = OP_M_C;
      end
      if (w_cntNext == CW'(3 * L - 1)) begin
        w_pe0Next.RES_delay_en = 1'b1;
      end
    end
  end

  // PE0 bundle output register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_pe0 <= PE_CTRL_IDLE;
    end else begin
      r_pe0 <= w_pe0Next;
    end
  end

  ctrl_skew_line #(
    .NUM_PE (NUM_PE),
    .L      (L)
  ) u_skew (
    .i_clock  (clock_i),
    .i_reset  (reset_i),
    .i_pe0    (r_pe0),
    .o_peCtrl (pe_ctrl_o)
  );

  assign busy_o  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done_o  = (r_state == ST_DONE);
  assign a_idx_o = (r_state == ST_RUN) ? r_iter : '0;

`ifdef FIOS_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  // Busy-cycle counter: restarts on a new operation, holds after it completes
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_cycles <= '0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_cycles <= '0;
    end else if (busy_o) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fios_casc_ctrl.sv
// Testbench for fios_casc_ctrl: three instances (L=3, L=1, L=2, all with four PEs)
// share one clock, reset and start. A reference model tracks each operation as a
// cycle offset since start acceptance and derives every output from that offset.
module tb_fios_casc_ctrl;
   import fios_casc_pkg::*;

   localparam int S    = 4;
   localparam int NDUT = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic checkEn = 1'b0;

   int nChecks = 0;
   int nPass   = 0;

   int phase [NDUT] = '{-1, -1, -1};
   int cyc   [NDUT] = '{0, 0, 0};

   logic busy0, busy1, busy2;
   logic done0, done1, done2;
   logic [1:0] aIdx0, aIdx1, aIdx2;
   pe_ctrl_t [S-1:0] pe0, pe1, pe2;
   logic [31:0] cycles0, cycles1, cycles2;

   logic busyA [NDUT];
   logic doneA [NDUT];
   logic [1:0] aIdxA [NDUT];
   pe_ctrl_t [S-1:0] peA [NDUT];
   logic [31:0] cyclesA [NDUT];

   assign busyA[0] = busy0;
   assign busyA[1] = busy1;
   assign busyA[2] = busy2;
   assign doneA[0] = done0;
   assign doneA[1] = done1;
   assign doneA[2] = done2;
   assign aIdxA[0] = aIdx0;
   assign aIdxA[1] = aIdx1;
   assign aIdxA[2] = aIdx2;
   assign peA[0] = pe0;
   assign peA[1] = pe1;
   assign peA[2] = pe2;
   assign cyclesA[0] = cycles0;
   assign cyclesA[1] = cycles1;
   assign cyclesA[2] = cycles2;

   always #5 clock = ~clock;

   fios_casc_ctrl #(.NUM_PE(S), .ABREG(1), .MREG(1)) dut3 (
      .clock_i(clock), .reset_i(reset), .start_i(start),
      .busy_o(busy0), .done_o(done0), .a_idx_o(aIdx0),
      .pe_ctrl_o(pe0), .cycles_o(cycles0)
   );

   fios_casc_ctrl #(.NUM_PE(S), .ABREG(0), .MREG(0)) dut1 (
      .clock_i(clock), .reset_i(reset), .start_i(start),
      .busy_o(busy1), .done_o(done1), .a_idx_o(aIdx1),
      .pe_ctrl_o(pe1), .cycles_o(cycles1)
   );

   fios_casc_ctrl #(.NUM_PE(S), .ABREG(1), .MREG(0)) dut2 (
      .clock_i(clock), .reset_i(reset), .start_i(start),
      .busy_o(busy2), .done_o(done2), .a_idx_o(aIdx2),
      .pe_ctrl_o(pe2), .cycles_o(cycles2)
   );

   function automatic int lOf(input int m);
      case (m)
         0:       return 3;
         1:       return 1;
         default: return 2;
      endcase
   endfunction

   // Expected bundle on PE k, p cycles into an operation (p=1 is the first RUN cycle)
   function automatic pe_ctrl_t expBundle(input int m, input int k, input int p);
      pe_ctrl_t b;
      int L, T, u, it, c;
      b = PE_CTRL_IDLE;
      L = lOf(m);
      T = 3 * L;
      if (p < 1) return b;
      u = p - 1 - k * L;
      if (u < 0 || u >= S * T) return b;
      it = u / T;
      c  = u % T;
      if (c == 0) begin
         b.a_reg_en  = 1'b1;
         b.mux_A_sel = 2'd0;
         b.mux_B_sel = 2'd0;
         b.CREG_en   = 1'b1;
         b.OPMODE    = (it == 0) ? 9'h005 : 9'h185;
         b.mux_C_sel = (it == 0) ? 2'd3 : 2'd1;
      end
      if (c == L) begin
         b.mux_A_sel = 2'd1;
         b.mux_B_sel = 2'd1;
         b.OPMODE    = 9'h005;
      end
      if (c == 2 * L - 1) b.m_reg_en = 1'b1;
      if (c == 2 * L) begin
         b.mux_A_sel = 2'd2;
         b.mux_B_sel = 2'd2;
         b.mux_C_sel = 2'd2;
         b.CREG_en   = 1'b1;
         b.OPMODE    = (k == 0) ? 9'h185 : 9'h1D5;
      end
      if (c == 3 * L - 1) b.RES_delay_en = 1'b1;
      return b;
   endfunction

   // Reference model: one operation spans RUN (3SL), DRAIN (SL) and one DONE cycle
   always @(posedge clock) begin
      for (int m = 0; m < NDUT; m++) begin
         if (reset) begin
            phase[m] = -1;
            cyc[m]   = 0;
         end else if (phase[m] < 0) begin
            if (start) begin
               phase[m] = 1;
               cyc[m]   = 0;
            end
         end else begin
            if (phase[m] <= 4 * S * lOf(m)) cyc[m] = cyc[m] + 1;
            if (phase[m] == 4 * S * lOf(m) + 1) phase[m] = -1;
            else phase[m] = phase[m] + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end else begin
         nPass++;
      end
   endtask

   // Compare every DUT output against the model on each falling edge
   always @(negedge clock) begin
      if (checkEn) begin
         for (int m = 0; m < NDUT; m++) begin
            int p, L, expCyc;
            p = phase[m];
            L = lOf(m);
`ifdef FIOS_CTRL_CYCLE_CNT_EN
            expCyc = cyc[m];
`else
            expCyc = 0;
`endif
            checkOutput($sformatf("dut%0d.busy", m), 32'(busyA[m]),
                        (p >= 1 && p <= 4 * S * L) ? 32'd1 : 32'd0);
            checkOutput($sformatf("dut%0d.done", m), 32'(doneA[m]),
                        (p == 4 * S * L + 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("dut%0d.a_idx", m), 32'(aIdxA[m]),
                        (p >= 1 && p <= 3 * S * L) ? 32'((p - 1) / (3 * L)) : 32'd0);
            checkOutput($sformatf("dut%0d.cycles", m), cyclesA[m], 32'(expCyc));
            for (int k = 0; k < S; k++) begin
               checkOutput($sformatf("dut%0d.pe%0d", m, k), 32'(peA[m][k]),
                           32'(expBundle(m, k, p)));
            end
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic s, input int n);
      repeat (n) begin
         @(negedge clock);
         reset = r;
         start = s;
      end
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b1, 1'b0, 3);
      checkEn = 1'b1;
      applyStimulus(1'b0, 1'b0, 2);

      // single start pulse, full operation on every instance
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 70);

      // start held high: back-to-back operations, no overlap
      applyStimulus(1'b0, 1'b1, 130);
      applyStimulus(1'b0, 1'b0, 60);

      // reset in cycle 20 of an operation, then a clean restart
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 19);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 3);
      applyStimulus(1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 60);

      // random start and occasional reset
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) == 0), 1);
      end
      applyStimulus(1'b0, 1'b0, 60);

      @(negedge clock);
      checkEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
